// File: rtl/exe_pipe_sequencer.sv
// Execution-stage pipe sequencer: global stall, pipe-fill window, branch flush pulse,
// load-use bubble insertion and a saturating stalled-cycle counter for debug.
module exe_pipe_sequencer #(
  parameter int FILL_DEPTH = 4,
  parameter int HAZ_CYCLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rdy_i,
  input  logic        mem_stl_i,
  input  logic        flush_req_i,
  input  logic        hazard_i,
  output logic        gbl_stl_o,
  output logic        wait_to_fill_pipe_o,
  output logic        flush_o,
  output logic        flush_ack_o,
  output logic [1:0]  state_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_FILL = 2'b00,
    ST_RUN  = 2'b01,
    ST_HAZ  = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] FILL_LOAD = CNT_W'(FILL_DEPTH - 1);
  localparam logic [CNT_W-1:0] HAZ_LOAD  = CNT_W'(HAZ_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             frozen;
  logic             adv;
  logic             ack;
  logic             flush_q;
  logic [15:0]      stall_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign gbl_stl_o = ~rst_n_i | ~rdy_i | (state == ST_HAZ);
  assign frozen    = ~rdy_i | mem_stl_i;
  assign adv       = ~gbl_stl_o & ~mem_stl_i;

  // HAZ always stalls, so a flush there bypasses the adv qualifier to abort the bubble.
  always_comb begin
    ack = 1'b0;
    unique case (state)
      ST_FILL, ST_RUN: ack = adv & flush_req_i;
      ST_HAZ:          ack = rst_n_i & flush_req_i;
      default:         ack = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_BAD) begin
      state_nxt = ST_FILL;
      cnt_nxt   = FILL_LOAD;
    end else if (ack) begin
      state_nxt = ST_FILL;
      cnt_nxt   = FILL_LOAD;
    end else if (!frozen) begin
      unique case (state)
        ST_FILL: begin
          if (cnt == '0) state_nxt = ST_RUN;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        ST_RUN: begin
          if (hazard_i) begin
            state_nxt = ST_HAZ;
            cnt_nxt   = HAZ_LOAD;
          end
        end
        ST_HAZ: begin
          if (cnt == '0) state_nxt = ST_RUN;
          else           cnt_nxt   = cnt - CNT_ONE;
        end
        default: begin
          state_nxt = ST_FILL;
          cnt_nxt   = FILL_LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= ST_FILL;
      cnt     <= FILL_LOAD;
      flush_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      flush_q <= ack;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)       stall_cnt <= 16'd0;
    else if (gbl_stl_o) stall_cnt <= sat_inc(stall_cnt);
  end

  assign flush_ack_o         = ack;
  assign flush_o             = flush_q & (state != ST_BAD);
  assign wait_to_fill_pipe_o = (state == ST_FILL);
  assign state_o             = state;
  assign stall_cnt_o         = stall_cnt;

endmodule
